// File: rtl/barrel_shift_arbiter_pkg.sv
// barrel_shift_arbiter_pkg: shared widths, direction codes and FSM state type for the shift arbiter.
package barrel_shift_arbiter_pkg;
   localparam int DATA_W = 4;
   localparam int AMT_W = 2;
   localparam logic DIR_LEFT = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   typedef enum logic {IDLE, FULL} state_t;
endpackage

// File: rtl/barrel_shift_arbiter_if.sv
// barrel_shift_arbiter_if: two-requester request bus plus single result channel.
interface barrel_shift_arbiter_if;
   import barrel_shift_arbiter_pkg::*;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [AMT_W-1:0] req_amt0;
   logic [AMT_W-1:0] req_amt1;
   logic req_dir0;
   logic req_dir1;
   logic out_valid;
   logic out_ready;
   logic [DATA_W-1:0] out_data;
   logic out_id;
   modport master (
      output req_valid, req_data0, req_data1, req_amt0, req_amt1, req_dir0, req_dir1, out_ready,
      input req_ready, out_valid, out_data, out_id
   );
   modport slave (
      input req_valid, req_data0, req_data1, req_amt0, req_amt1, req_dir0, req_dir1, out_ready,
      output req_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational zero-filling logical shift, left or right.
module barrel_shifter
   import barrel_shift_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  shift_amt,
   input  logic              direction,
   output logic [DATA_W-1:0] data_out
);
   assign data_out = (direction == DIR_RIGHT) ? data_in >> shift_amt : data_in << shift_amt;
endmodule

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin arbitration of two shift requests into a one-entry result register.
module barrel_shift_arbiter
   import barrel_shift_arbiter_pkg::*;
(
   input logic clk,
   input logic rst,
   barrel_shift_arbiter_if.slave bus
);
   state_t state, next_state;
   logic last, g, slot_free, accept, sel_dir;
   logic [DATA_W-1:0] sel_data, shifted;
   logic [AMT_W-1:0] sel_amt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= next_state;
   end

   always_comb begin
      next_state = accept ? FULL : (state == FULL && !bus.out_ready) ? FULL : IDLE;
   end

   // Under contention the requester not served last wins; otherwise whichever is valid.
   always_comb begin
      slot_free = (state == IDLE) || bus.out_ready;
      g = (&bus.req_valid) ? ~last : bus.req_valid[1];
      bus.req_ready = (slot_free && !rst && bus.req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
      bus.out_valid = (state == FULL);
      accept = |(bus.req_valid & bus.req_ready);
      sel_data = g ? bus.req_data1 : bus.req_data0;
      sel_amt = g ? bus.req_amt1 : bus.req_amt0;
      sel_dir = g ? bus.req_dir1 : bus.req_dir0;
   end

   barrel_shifter u_shifter (
      .data_in(sel_data),
      .shift_amt(sel_amt),
      .direction(sel_dir),
      .data_out(shifted)
   );

   // Pointer resets to 1 so requester 0 wins the first contended slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_data <= '0;
         bus.out_id <= 1'b0;
         last <= 1'b1;
      end else if (accept) begin
         bus.out_data <= shifted;
         bus.out_id <= g;
         last <= g;
      end
   end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed and random stimulus against a cycle-level reference model.
module tb_barrel_shift_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   barrel_shift_arbiter_if bus();
   barrel_shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int compared = 0;
   int mismatched = 0;
   bit mv;
   int md, mid, last;

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int shf(input int d, input int k, input int dir);
      return dir != 0 ? d / (1 << k) : (d * (1 << k)) % 16;
   endfunction

   always @(negedge clk) begin
      chk("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
      if (bus.out_valid && !bus.out_ready && !rst) chk("no_accept_stalled", int'(bus.req_ready), 0);
   end

   task automatic drive(input int v, input int d0, input int a0, input int r0,
                        input int d1, input int a1, input int r1, input int ordy);
      bus.req_valid = 2'(v);
      bus.req_data0 = 4'(d0);
      bus.req_amt0 = 2'(a0);
      bus.req_dir0 = 1'(r0);
      bus.req_data1 = 4'(d1);
      bus.req_amt1 = 2'(a1);
      bus.req_dir1 = 1'(r1);
      bus.out_ready = 1'(ordy);
   endtask

   task automatic cycle();
      int v, g, res, er;
      bit acc, ordy;
      #2;
      v = int'(bus.req_valid);
      ordy = bus.out_ready;
      g = (v == 3) ? 1 - last : (v == 2 ? 1 : 0);
      acc = (v != 0) && (!mv || ordy);
      er = acc ? (1 << g) : 0;
      chk("req_ready", int'(bus.req_ready), er);
      res = g != 0 ? shf(int'(bus.req_data1), int'(bus.req_amt1), int'(bus.req_dir1))
                   : shf(int'(bus.req_data0), int'(bus.req_amt0), int'(bus.req_dir0));
      @(posedge clk);
      #1;
      if (acc) begin
         mv = 1'b1;
         md = res;
         mid = g;
         last = g;
      end else if (mv && ordy) mv = 1'b0;
      chk("out_valid", int'(bus.out_valid), int'(mv));
      if (mv) begin
         chk("out_data", int'(bus.out_data), md);
         chk("out_id", int'(bus.out_id), mid);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_id", int'(bus.out_id), 0);
      chk("rst_req_ready", int'(bus.req_ready), 0);
      mv = 1'b0;
      md = 0;
      mid = 0;
      last = 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int held;
      drive(3, 15, 3, 1, 9, 2, 0, 1);
      do_reset();
      drive(1, 11, 1, 0, 0, 0, 0, 1);
      cycle();
      chk("single_valid", int'(bus.out_valid), 1);
      chk("single_data", int'(bus.out_data), 6);
      chk("single_id", int'(bus.out_id), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      cycle();
      chk("single_drain", int'(bus.out_valid), 0);
      do_reset();
      drive(3, 15, 3, 1, 9, 2, 0, 1);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("alt_data", int'(bus.out_data), (i % 2 != 0) ? 4 : 1);
         chk("alt_id", int'(bus.out_id), i % 2);
      end
      bus.out_ready = 1'b0;
      held = int'(bus.out_data);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_valid", int'(bus.out_valid), 1);
         chk("bp_data", int'(bus.out_data), held);
      end
      bus.out_ready = 1'b1;
      cycle();
      chk("bp_release_id", int'(bus.out_id), 0);
      drive(1, 8, 3, 0, 0, 0, 0, 1);
      cycle();
      chk("left3", int'(bus.out_data), 0);
      drive(1, 8, 3, 1, 0, 0, 0, 1);
      cycle();
      chk("right3", int'(bus.out_data), 1);
      drive(2, 0, 0, 0, 5, 0, 0, 1);
      cycle();
      chk("amt0_left", int'(bus.out_data), 5);
      drive(2, 0, 0, 0, 10, 0, 1, 1);
      cycle();
      chk("amt0_right", int'(bus.out_data), 10);
      drive(3, 15, 3, 1, 9, 2, 0, 0);
      cycle();
      chk("pre_rst_full", int'(bus.out_valid), 1);
      do_reset();
      drive(3, 15, 3, 1, 9, 2, 0, 1);
      cycle();
      chk("post_rst_grant", int'(bus.out_id), 0);
      for (int i = 0; i < 300; i++) begin
         drive(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(1, 0)), int'($urandom_range(3, 0) != 0));
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
